// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM
// Sequences the shared ALU, memory port and register file over several clocks per instruction.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op_c,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       ir_we,
   output logic       iord_c,
   output logic       mw_c,
   output logic       we_c,
   output logic       dest_reg_c,
   output logic       result_c,
   output logic       argA_c,
   output logic [1:0] argB_c,
   output logic [1:0] pc_next_c,
   output logic [3:0] alu_c,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   state_t     cur_state;
   state_t     nxt_state;
   logic [3:0] funct_alu;

   // Unknown funct codes quietly execute as add rather than trapping.
   always_comb begin
      funct_alu = ALU_ADD;
      case (funct)
         6'h20:   funct_alu = ALU_ADD;
         6'h22:   funct_alu = ALU_SUB;
         6'h24:   funct_alu = ALU_AND;
         6'h25:   funct_alu = ALU_OR;
         6'h2A:   funct_alu = ALU_SLT;
         default: funct_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      nxt_state = S_FETCH;
      case (cur_state)
         S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op_c)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_RTYPE:     nxt_state = S_EXEC;
               OP_BEQ:       nxt_state = S_BRANCH;
               OP_ADDI:      nxt_state = S_ADDIEX;
               OP_J:         nxt_state = S_JUMP;
               default:      nxt_state = S_FETCH;
            endcase
         end
         S_MEMADR: nxt_state = (op_c == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   nxt_state = S_ALUWB;
         S_ADDIEX: nxt_state = S_ADDIWB;
         default:  nxt_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cur_state <= S_FETCH;
      else        cur_state <= nxt_state;
   end

   always_comb begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      iord_c     = 1'b0;
      mw_c       = 1'b0;
      we_c       = 1'b0;
      dest_reg_c = 1'b0;
      result_c   = 1'b0;
      argA_c     = 1'b0;
      argB_c     = 2'b00;
      pc_next_c  = 2'b00;
      alu_c      = 4'b0000;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      state      = cur_state;
      case (cur_state)
         S_FETCH: begin
            argB_c = 2'b01;
            alu_c  = ALU_ADD;
            pc_we  = mem_ready;
            ir_we  = mem_ready;
         end
         S_DECODE: begin
            argB_c = 2'b11;
            alu_c  = ALU_ADD;
            illegal_op = !(op_c == OP_RTYPE || op_c == OP_LW || op_c == OP_SW ||
                           op_c == OP_BEQ || op_c == OP_ADDI || op_c == OP_J);
         end
         S_MEMADR, S_ADDIEX: begin
            argA_c = 1'b1;
            argB_c = 2'b10;
            alu_c  = ALU_ADD;
         end
         S_MEMRD: iord_c = 1'b1;
         S_MEMWB: begin
            we_c       = 1'b1;
            result_c   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            iord_c     = 1'b1;
            mw_c       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            argA_c = 1'b1;
            alu_c  = funct_alu;
         end
         S_ALUWB: begin
            we_c       = 1'b1;
            dest_reg_c = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            argA_c     = 1'b1;
            alu_c      = ALU_SUB;
            pc_next_c  = 2'b01;
            pc_we      = zero;
            instr_done = 1'b1;
         end
         S_ADDIWB: begin
            we_c       = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pc_next_c  = 2'b10;
            pc_we      = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      // Reset shows the FETCH selects immediately, with every enable held off.
      if (!rst_n) begin
         pc_we      = 1'b0;
         ir_we      = 1'b0;
         iord_c     = 1'b0;
         mw_c       = 1'b0;
         we_c       = 1'b0;
         dest_reg_c = 1'b0;
         result_c   = 1'b0;
         argA_c     = 1'b0;
         argB_c     = 2'b01;
         pc_next_c  = 2'b00;
         alu_c      = ALU_ADD;
         instr_done = 1'b0;
         illegal_op = 1'b0;
         state      = S_FETCH;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
// Each task queues per-cycle stimulus with the expected output vector and compares at negedge.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op_c = 6'h00;
   logic [5:0] funct = 6'h20;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_we, ir_we, iord_c, mw_c, we_c, dest_reg_c, result_c, argA_c;
   logic [1:0] argB_c, pc_next_c;
   logic [3:0] alu_c, state;
   logic       instr_done, illegal_op;

   int checks = 0;
   int failures = 0;

   logic [2:0]  stim_q[$];
   logic [21:0] exp_q[$];
   logic [21:0] outv;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op_c(op_c), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .iord_c(iord_c),
      .mw_c(mw_c), .we_c(we_c), .dest_reg_c(dest_reg_c), .result_c(result_c),
      .argA_c(argA_c), .argB_c(argB_c), .pc_next_c(pc_next_c), .alu_c(alu_c),
      .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign outv = {state, pc_we, ir_we, iord_c, mw_c, we_c, dest_reg_c, result_c,
                  argA_c, argB_c, pc_next_c, alu_c, instr_done, illegal_op};

   // Fields: state pc_we ir_we iord mw we dest res argA argB pc_next alu done illegal
   function automatic logic [21:0] mk(input int st, input int pw, input int iw, input int io,
                                      input int mw, input int we, input int dr, input int rs,
                                      input int a, input int b, input int pn, input int alu,
                                      input int dn, input int il);
      logic [3:0] st4, alu4;
      logic [1:0] b2, pn2;
      st4 = st[3:0]; alu4 = alu[3:0]; b2 = b[1:0]; pn2 = pn[1:0];
      return {st4, pw[0], iw[0], io[0], mw[0], we[0], dr[0], rs[0], a[0], b2, pn2, alu4,
              dn[0], il[0]};
   endfunction

   // Stimulus bits: {rst_n, mem_ready, zero}
   task automatic plan(input logic [2:0] s, input logic [21:0] e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      int n = 0;
      logic [2:0] s;
      logic [21:0] e;
      op_c = 6'h00; funct = 6'h22;
      plan(3'b010, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b010, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b100, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
      plan(3'b010, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b010, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b110, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
      plan(3'b110, mk(6,0,0,0,0,0,0,0,1,0,0,6,0,0));
      plan(3'b110, mk(7,0,0,0,0,1,1,0,0,0,0,0,1,0));
      plan(3'b100, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outv !== e) begin
            failures++;
            $display("FAIL reset cycle %0d: got %h expected %h", n, outv, e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rtype_alu();
      logic [5:0] fn[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
      int         al[6] = '{2, 6, 0, 1, 7, 2};
      logic [2:0] s;
      logic [21:0] e;
      for (int k = 0; k < 6; k++) begin
         int n = 0;
         op_c = 6'h00; funct = fn[k];
         plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
         plan(3'b110, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
         plan(3'b110, mk(6,0,0,0,0,0,0,0,1,0,0,al[k],0,0));
         plan(3'b110, mk(7,0,0,0,0,1,1,0,0,0,0,0,1,0));
         plan(3'b100, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
         while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (outv !== e) begin
               failures++;
               $display("FAIL rtype funct=%h cycle %0d: got %h expected %h", fn[k], n, outv, e);
            end
            n++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_lw_stall();
      int n = 0;
      logic [2:0] s;
      logic [21:0] e;
      op_c = 6'h23;
      plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b100, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
      plan(3'b100, mk(2,0,0,0,0,0,0,0,1,2,0,2,0,0));
      plan(3'b100, mk(3,0,0,1,0,0,0,0,0,0,0,0,0,0));
      plan(3'b100, mk(3,0,0,1,0,0,0,0,0,0,0,0,0,0));
      plan(3'b110, mk(3,0,0,1,0,0,0,0,0,0,0,0,0,0));
      plan(3'b100, mk(4,0,0,0,0,1,0,1,0,0,0,0,1,0));
      plan(3'b100, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outv !== e) begin
            failures++;
            $display("FAIL lw cycle %0d: got %h expected %h", n, outv, e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw_stall();
      int n = 0;
      logic [2:0] s;
      logic [21:0] e;
      op_c = 6'h2B;
      plan(3'b100, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b110, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
      plan(3'b110, mk(2,0,0,0,0,0,0,0,1,2,0,2,0,0));
      plan(3'b100, mk(5,0,0,1,1,0,0,0,0,0,0,0,0,0));
      plan(3'b110, mk(5,0,0,1,1,0,0,0,0,0,0,0,1,0));
      plan(3'b100, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outv !== e) begin
            failures++;
            $display("FAIL sw cycle %0d: got %h expected %h", n, outv, e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_beq();
      logic [2:0] s;
      logic [21:0] e;
      for (int z = 1; z >= 0; z--) begin
         int n = 0;
         op_c = 6'h04;
         plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
         plan({2'b11, ~z[0]}, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
         plan({2'b10, z[0]}, mk(8,z,0,0,0,0,0,0,1,0,1,6,1,0));
         plan({2'b10, ~z[0]}, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
         while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (outv !== e) begin
               failures++;
               $display("FAIL beq zero=%0d cycle %0d: got %h expected %h", z, n, outv, e);
            end
            n++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_addi_jump_illegal();
      int n = 0;
      logic [2:0] s;
      logic [21:0] e;
      op_c = 6'h08;
      plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b100, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
      plan(3'b100, mk(9,0,0,0,0,0,0,0,1,2,0,2,0,0));
      plan(3'b100, mk(10,0,0,0,0,1,0,0,0,0,0,0,1,0));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outv !== e) begin
            failures++;
            $display("FAIL addi cycle %0d: got %h expected %h", n, outv, e);
         end
         n++;
         @(posedge clk); #1;
      end
      op_c = 6'h02;
      plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b110, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,0));
      plan(3'b110, mk(11,1,0,0,0,0,0,0,0,0,2,0,1,0));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outv !== e) begin
            failures++;
            $display("FAIL jump cycle %0d: got %h expected %h", n, outv, e);
         end
         n++;
         @(posedge clk); #1;
      end
      op_c = 6'h3F;
      plan(3'b110, mk(0,1,1,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b110, mk(1,0,0,0,0,0,0,0,0,3,0,2,0,1));
      plan(3'b100, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      plan(3'b100, mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0));
      while (exp_q.size() != 0) begin
         s = stim_q.pop_front(); rst_n = s[2]; mem_ready = s[1]; zero = s[0];
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (outv !== e) begin
            failures++;
            $display("FAIL illegal cycle %0d: got %h expected %h", n, outv, e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_rtype_alu();
      test_lw_stall();
      test_sw_stall();
      test_beq();
      test_addi_jump_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
